// File: rtl/iq_sched_if.sv
// Issue-queue scheduler bus.
// Groups the dispatch (alloc_*), wakeup (wake_sel), issue (issue_*), occupancy
// (count), flush and age-array (age_*) signals of iq_sched.
//   slave  : the scheduler side (iq_sched)
//   master : the surrounding pipeline / age-array side
interface iq_sched_if #(
    parameter int ENTRIES = 16,
    parameter int IW      = $clog2(ENTRIES)
);
    logic               flush;
    logic               alloc_valid;
    logic               alloc_rdy;
    logic               alloc_ready;
    logic [IW-1:0]      alloc_idx;
    logic [ENTRIES-1:0] wake_sel;
    logic               issue_ready;
    logic               issue_valid;
    logic [IW-1:0]      issue_idx;
    logic [IW:0]        count;
    logic               age_set_row_valid;
    logic [ENTRIES-1:0] age_set_row_sel;
    logic               age_clear_col_valid;
    logic [ENTRIES-1:0] age_clear_col_sel;
    logic [ENTRIES-1:0] age_row_sel;
    logic [ENTRIES-1:0] age_col_sel;

    modport slave (
        input  flush, alloc_valid, alloc_rdy, wake_sel, issue_ready, age_col_sel,
        output alloc_ready, alloc_idx, issue_valid, issue_idx, count,
               age_set_row_valid, age_set_row_sel, age_clear_col_valid,
               age_clear_col_sel, age_row_sel
    );

    modport master (
        output flush, alloc_valid, alloc_rdy, wake_sel, issue_ready, age_col_sel,
        input  alloc_ready, alloc_idx, issue_valid, issue_idx, count,
               age_set_row_valid, age_set_row_sel, age_clear_col_valid,
               age_clear_col_sel, age_row_sel
    );
endinterface

// File: rtl/iq_sched.sv
// Issue-queue scheduler with an external age array.
// Each entry walks FREE -> NEW -> (WAIT ->) RDY -> FREE. Allocation picks the
// lowest FREE entry; among RDY entries the age array selects the oldest, and
// one entry may be issued per cycle alongside one allocation.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : iq_sched_if.slave -- flush, alloc_*, wake_sel, issue_*, count, age_*
module iq_sched #(
    parameter int ENTRIES = 16,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    iq_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_NEW  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RDY  = 2'd3
    } ent_state_e;

    ent_state_e         state_q [ENTRIES];
    ent_state_e         state_d [ENTRIES];
    logic [ENTRIES-1:0] new_rdy_q;      // operands ready at dispatch
    logic [IW:0]        count_q;
    logic               issue_valid_q;
    logic [IW-1:0]      issue_idx_q;
    logic               clr_vld_p1;     // column clear owed for last cycle's alloc
    logic [IW-1:0]      clr_idx_p1;

    logic [ENTRIES-1:0] free_vec;
    logic [ENTRIES-1:0] req_vec;
    logic [ENTRIES-1:0] grant;
    logic               any_free;
    logic [IW-1:0]      free_idx;
    logic [IW-1:0]      grant_idx;
    logic               alloc_acc;
    logic               issue_acc;

    // Output/decode logic from the current state
    always_comb begin
        free_vec = '0;
        req_vec  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec[i] = (state_q[i] == ST_FREE);
            req_vec[i]  = (state_q[i] == ST_RDY);
        end
    end

    // Descending scan so the lowest FREE index is the last one written
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx = IW'(i);
                any_free = 1'b1;
            end
        end
    end

    // An entry is granted only if no older entry is also requesting
    assign grant = req_vec & ~bus.age_col_sel;

    // grant is one-hot, so OR-ing the set indices encodes it
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i]) grant_idx = grant_idx | IW'(i);
        end
    end

    assign alloc_acc = ~rst & ~bus.flush & bus.alloc_valid & any_free;
    assign issue_acc = ~rst & ~bus.flush & bus.issue_ready & (|grant);

    // Next-state logic per entry
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_FREE: if (alloc_acc && (free_idx == IW'(i))) state_d[i] = ST_NEW;
                ST_NEW:  state_d[i] = (new_rdy_q[i] || bus.wake_sel[i]) ? ST_RDY : ST_WAIT;
                ST_WAIT: if (bus.wake_sel[i]) state_d[i] = ST_RDY;
                ST_RDY:  if (issue_acc && grant[i]) state_d[i] = ST_FREE;
                default: state_d[i] = ST_FREE;
            endcase
            if (bus.flush) state_d[i] = ST_FREE;
        end
    end

    // State register and control
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) state_q[i] <= ST_FREE;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            clr_vld_p1    <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) state_q[i] <= state_d[i];
            if (bus.flush) begin
                count_q       <= '0;
                issue_valid_q <= 1'b0;
                clr_vld_p1    <= 1'b0;
            end else begin
                count_q       <= count_q + (IW+1)'(alloc_acc) - (IW+1)'(issue_acc);
                issue_valid_q <= issue_acc;
                if (issue_acc) issue_idx_q <= grant_idx;
                clr_vld_p1    <= alloc_acc;
            end
        end
    end

    // Data-only registers; only meaningful while the matching state/valid is set
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            new_rdy_q[free_idx] <= bus.alloc_rdy;
            clr_idx_p1          <= free_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (|req_vec)) begin
            assert ($onehot(grant));
        end
    end

    assign bus.alloc_ready         = any_free;
    assign bus.alloc_idx           = free_idx;
    assign bus.issue_valid         = issue_valid_q;
    assign bus.issue_idx           = issue_idx_q;
    assign bus.count               = count_q;
    assign bus.age_set_row_valid   = alloc_acc;
    assign bus.age_set_row_sel     = ENTRIES'(1) << free_idx;
    // The pending clear always targets an entry now in NEW, never the one being allocated
    assign bus.age_clear_col_valid = clr_vld_p1 & ~rst & ~bus.flush;
    assign bus.age_clear_col_sel   = ENTRIES'(1) << clr_idx_p1;
    assign bus.age_row_sel         = req_vec;

endmodule

// File: tb/tb_iq_sched.sv
`timescale 1ns/1ps
module tb_iq_sched;
    localparam int E     = 16;
    localparam int IW    = 4;
    localparam int NEVER = 32'h7fffffff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iq_sched_if #(.ENTRIES(E), .IW(IW)) bus ();
    iq_sched #(.ENTRIES(E), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // External age array: age[r][c]=1 means entry r is younger than entry c
    logic [E-1:0] age [E] = '{default: '0};
    logic [E-1:0] col_sel;

    always_comb begin
        col_sel = '0;
        for (int i = 0; i < E; i++) col_sel[i] = |(age[i] & bus.age_row_sel);
    end
    assign bus.age_col_sel = col_sel;

    always @(posedge clk) begin
        for (int r = 0; r < E; r++) begin
            for (int c = 0; c < E; c++) begin
                if (bus.age_clear_col_valid && bus.age_clear_col_sel[c]) age[r][c] <= 1'b0;
                if (bus.age_set_row_valid && bus.age_set_row_sel[r] && r != c) age[r][c] <= 1'b1;
            end
        end
    end

    // Reference model: entries in allocation order, with the cycle each may first issue
    bit  live   [E];
    int  acyc   [E];
    int  rdy_at [E];
    int  ageq   [$];
    bit  m_iv;
    int  m_ii;
    bit  m_cv;
    int  m_ci;
    int  cyc;
    int  total;
    int  bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit av, input bit ar,
                        input logic [E-1:0] wk, input bit ir);
        int aidx;
        bit aok;
        bit found;
        int iss;
        logic [E-1:0] req;
        // registered outputs left by the previous edge
        chk("issue_valid", bus.issue_valid, m_iv);
        if (m_iv) chk("issue_idx", bus.issue_idx, m_ii);
        chk("count", bus.count, ageq.size());
        rst             = r;
        bus.flush       = f;
        bus.alloc_valid = av;
        bus.alloc_rdy   = ar;
        bus.wake_sel    = wk;
        bus.issue_ready = ir;
        #1;
        aok  = (ageq.size() < E);
        aidx = 0;
        found = 0;
        for (int i = 0; i < E; i++) if (!found && !live[i]) begin aidx = i; found = 1; end
        req = '0;
        for (int i = 0; i < E; i++) if (live[i] && rdy_at[i] <= cyc) req[i] = 1'b1;
        chk("alloc_ready", bus.alloc_ready, aok);
        if (aok) chk("alloc_idx", bus.alloc_idx, aidx);
        chk("row_sel", bus.age_row_sel, req);
        chk("set_vld", bus.age_set_row_valid, !r && !f && av && aok);
        if (!r && !f && av && aok) chk("set_sel", bus.age_set_row_sel, 32'd1 << aidx);
        chk("clr_vld", bus.age_clear_col_valid, !r && !f && m_cv);
        if (!r && !f && m_cv) chk("clr_sel", bus.age_clear_col_sel, 32'd1 << m_ci);

        // oldest ready entry wins
        iss = -1;
        if (!r && !f && ir)
            for (int k = 0; k < ageq.size(); k++)
                if (iss < 0 && req[ageq[k]]) iss = ageq[k];
        // wakeups count only once the entry has been allocated
        for (int i = 0; i < E; i++)
            if (wk[i] && live[i] && acyc[i] < cyc && rdy_at[i] > cyc + 1) rdy_at[i] = cyc + 1;

        if (r || f) begin
            for (int i = 0; i < E; i++) live[i] = 0;
            ageq.delete();
            m_iv = 0;
            m_cv = 0;
            if (r) m_ii = 0;
        end else begin
            m_iv = (iss >= 0);
            if (iss >= 0) begin
                m_ii = iss;
                live[iss] = 0;
                for (int k = ageq.size() - 1; k >= 0; k--) if (ageq[k] == iss) ageq.delete(k);
            end
            m_cv = av && aok;
            if (av && aok) begin
                live[aidx]   = 1;
                acyc[aidx]   = cyc;
                rdy_at[aidx] = ar ? cyc + 2 : NEVER;
                ageq.push_back(aidx);
                m_ci = aidx;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ir);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, ir);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        m_iv  = 0;
        m_ii  = 0;
        m_cv  = 0;
        m_ci  = 0;
        for (int i = 0; i < E; i++) begin live[i] = 0; acyc[i] = 0; rdy_at[i] = NEVER; end
        rst = 1'b1;
        bus.flush = 0; bus.alloc_valid = 0; bus.alloc_rdy = 0;
        bus.wake_sel = '0; bus.issue_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_issue_idx", bus.issue_idx, 0);
        chk("rst_alloc_idx", bus.alloc_idx, 0);

        // single ready op: set row cycle 1, clear col cycle 2, issue visible cycle 4
        step(0, 0, 1, 1, '0, 1);
        idle(4, 1);

        // three waiting ops woken as 2, then {0,1}: issue 2,0,1
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, '0, 1);
        idle(2, 1);
        step(0, 0, 0, 0, 16'h0004, 1);
        idle(1, 1);
        step(0, 0, 0, 0, 16'h0003, 1);
        idle(5, 1);

        // fill, stay full, then issue with alloc_valid held
        for (int k = 0; k < E; k++) step(0, 0, 1, k[0], '0, 0);
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 0, '1, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 0, '0, 1);

        // flush with live entries and alloc_valid high
        step(0, 1, 0, 0, '0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, '0, 0);
        step(0, 1, 1, 1, '1, 1);
        idle(2, 1);

        // issue stalled for 4 cycles with two ready entries
        step(0, 0, 1, 1, '0, 0);
        step(0, 0, 1, 1, '0, 0);
        idle(4, 0);
        idle(3, 1);

        // entry 0 reallocated behind older ready entries 1,2
        step(0, 1, 0, 0, '0, 0);
        step(0, 0, 1, 1, '0, 0);
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 0, '0, 1);
        step(0, 0, 1, 1, 16'h0006, 0);
        idle(1, 0);
        idle(4, 1);

        // reset in the middle of work
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 1, '0, 0);
        step(1, 1, 1, 1, '1, 1);
        idle(2, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, f, av, ar, ir;
            logic [E-1:0] wk;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 59) == 0);
            av = ($urandom_range(0, 9) < 7);
            ar = $urandom_range(0, 1);
            ir = ($urandom_range(0, 9) < 6);
            wk = E'($urandom & $urandom & $urandom);
            step(r, f, av, ar, wk, ir);
        end
        idle(20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
